// File: rtl/stg_pkg.sv
// Shared definitions for the storage command sequencer: target encoding,
// FSM state encoding and the opcode values forwarded to storage.
package stg_pkg;

  typedef enum logic [1:0] {
    TGT_BUF  = 2'd0,
    TGT_LIFO = 2'd1,
    TGT_FIFO = 2'd2,
    TGT_RSVD = 2'd3
  } tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Opcodes are opaque to the sequencer and passed straight through to storage.
  localparam logic [1:0] OP_NORMAL = 2'd0;
  localparam logic [1:0] OP_CLEAR  = 2'd1;
  localparam logic [1:0] OP_PEEK   = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  // A command is refused if its target cannot service it at issue time.
  function automatic logic cmd_rejected(input tgt_e tgt, input logic wr,
                                        input logic full, input logic empty);
    logic rej;
    case (tgt)
      TGT_BUF:            rej = 1'b0;
      TGT_LIFO, TGT_FIFO: rej = wr ? full : empty;
      TGT_RSVD:           rej = 1'b1;
      default:            rej = 1'b1;
    endcase
    return rej;
  endfunction

endpackage

// File: rtl/stg_cmd_seq.sv
// Host-to-storage command sequencer: accepts one command at a time, issues it
// to buffer/LIFO/FIFO for a single cycle and returns one response per command.
module stg_cmd_seq
  import stg_pkg::*;
#(
  parameter int DinLENGTH = 32,
  parameter int WIDTH     = 8,
  parameter int READ_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_target,
  input  logic                 cmd_write,
  input  logic [WIDTH-1:0]     cmd_addr,
  input  logic [DinLENGTH-1:0] cmd_data,
  input  logic [1:0]           cmd_opcode,
  output logic                 chip_en_buf,
  output logic                 chip_en_lifo,
  output logic                 chip_en_fifo,
  output logic [DinLENGTH-1:0] din,
  output logic [WIDTH-1:0]     addr,
  output logic                 r_w,
  output logic                 valid,
  output logic [1:0]           opcode,
  input  logic [DinLENGTH-1:0] dout,
  input  logic                 full,
  input  logic                 empty,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DinLENGTH-1:0] rsp_data,
  output logic                 rsp_err
);

  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT);

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  tgt_e                 tgt_q, tgt_d;
  logic                 write_q, write_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [DinLENGTH-1:0] data_q, data_d;
  logic [1:0]           op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DinLENGTH-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 reject_s;
  logic                 issue_s;

  // full/empty only matter while the command is actually being issued.
  assign reject_s = cmd_rejected(tgt_q, write_q, full, empty);
  assign issue_s  = (state_q == ST_ISSUE) && !reject_s;

  // Next-state and datapath update logic for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    tgt_d       = tgt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          tgt_d       = tgt_e'(cmd_target);
          write_d     = cmd_write;
          addr_d      = cmd_addr;
          data_d      = cmd_data;
          op_d        = cmd_opcode;
          cmd_ready_d = 1'b0;
          state_d     = ST_ISSUE;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (reject_s || write_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = reject_s;
          rsp_data_d  = '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // cnt_q tracks clocks since issue; dout is valid on the final count.
        if (cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = dout;
          cnt_d       = '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      tgt_q       <= TGT_BUF;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      op_q        <= 2'd0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      tgt_q       <= tgt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign valid        = issue_s;
  assign chip_en_buf  = issue_s && (tgt_q == TGT_BUF);
  assign chip_en_lifo = issue_s && (tgt_q == TGT_LIFO);
  assign chip_en_fifo = issue_s && (tgt_q == TGT_FIFO);
  assign din          = data_q;
  assign addr         = addr_q;
  assign r_w          = write_q;
  assign opcode       = op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_stg_cmd_seq.sv
// Directed bench for stg_cmd_seq with a behavioural storage model and a
// response scoreboard.
module tb_stg_cmd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_target;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [1:0]  cmd_opcode;
  logic        chip_en_buf, chip_en_lifo, chip_en_fifo;
  logic [31:0] din;
  logic [7:0]  addr;
  logic        r_w, valid;
  logic [1:0]  opcode;
  logic [31:0] dout;
  logic        full, empty;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  logic [31:0] mem [256];
  logic [31:0] fifo_m[$];
  logic [31:0] lifo_m[$];

  stg_cmd_seq #(.DinLENGTH(32), .WIDTH(8), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_opcode(cmd_opcode),
    .chip_en_buf(chip_en_buf), .chip_en_lifo(chip_en_lifo), .chip_en_fifo(chip_en_fifo),
    .din(din), .addr(addr), .r_w(r_w), .valid(valid), .opcode(opcode),
    .dout(dout), .full(full), .empty(empty),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Storage model: one-cycle read latency.
  always @(posedge clk) begin
    if (valid) begin
      if (chip_en_buf) begin
        if (r_w) mem[addr] <= din;
        else dout <= mem[addr];
      end
      if (chip_en_fifo) begin
        if (r_w) fifo_m.push_back(din);
        else if (fifo_m.size() > 0) dout <= fifo_m.pop_front();
      end
      if (chip_en_lifo) begin
        if (r_w) lifo_m.push_back(din);
        else if (lifo_m.size() > 0) dout <= lifo_m.pop_back();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] tgt, input logic wr,
                        input logic [7:0] a, input logic [31:0] d,
                        input logic f, input logic e, input logic exp_err,
                        input logic [31:0] exp_data, input int exp_lat, input int hold);
    int guard, cyc, pulses;
    logic [2:0] mask, exp_mask;
    logic [32:0] expv;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_target = tgt; cmd_write = wr; cmd_addr = a; cmd_data = d;
    cmd_opcode = d[1:0]; full = f; empty = e; rsp_ready = (hold == 0);
    cmd_valid  = 1'b1;
    exp_q.push_back({exp_err, exp_data});
    exp_mask = (tgt == 2'd0) ? 3'b100 : (tgt == 2'd1) ? 3'b010 : 3'b001;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0; pulses = 0; mask = 3'b000;
    @(negedge clk);
    while (!rsp_valid && cyc < 20) begin
      cyc++;
      if (valid) begin
        pulses++;
        mask = {chip_en_buf, chip_en_lifo, chip_en_fifo};
        chk({tag, " r_w"}, {31'd0, r_w}, {31'd0, wr});
        chk({tag, " addr"}, {24'd0, addr}, {24'd0, a});
        chk({tag, " din"}, din, d);
        chk({tag, " opcode"}, {30'd0, opcode}, {30'd0, d[1:0]});
      end else begin
        chk({tag, " en_idle"}, {29'd0, chip_en_buf, chip_en_lifo, chip_en_fifo}, 32'd0);
      end
      @(negedge clk);
    end
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " pulses"}, pulses, exp_err ? 32'd0 : 32'd1);
    if (pulses == 1) chk({tag, " chip_en"}, {29'd0, mask}, {29'd0, exp_mask});
    expv = exp_q.pop_front();
    chk({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, expv[32]});
    chk({tag, " rsp_data"}, rsp_data, expv[31:0]);
    chk({tag, " busy"}, {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, " hold_data"}, rsp_data, expv[31:0]);
      chk({tag, " hold_busy"}, {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " rsp_done"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, " ready_back"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_target = 2'd0; cmd_write = 1'b0;
    cmd_addr = 8'd0; cmd_data = 32'd0; cmd_opcode = 2'd0;
    full = 1'b0; empty = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst valid", {31'd0, valid}, 32'd0);
    chk("rst chip_en", {29'd0, chip_en_buf, chip_en_lifo, chip_en_fifo}, 32'd0);
    chk("rst din", din, 32'd0);
    chk("rst addr_rw_op", {21'd0, addr, r_w, opcode}, 32'd0);
    chk("rst rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst rsp_data", rsp_data, 32'd0);
    chk("rst rsp_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst cmd_ready", {31'd0, cmd_ready}, 32'd1);

    do_cmd("buf_wr", 2'd0, 1'b1, 8'h03, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'd0, 1, 0);
    do_cmd("buf_rd", 2'd0, 1'b0, 8'h03, 32'h0, 1'b1, 1'b1, 1'b0, 32'h12345678, 2, 0);
    do_cmd("lifo_rd_empty", 2'd1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b1, 32'd0, 1, 0);
    do_cmd("rsvd_wr", 2'd3, 1'b1, 8'h11, 32'h5555AAAA, 1'b0, 1'b0, 1'b1, 32'd0, 1, 0);

    do_cmd("fifo_wr0", 2'd2, 1'b1, 8'h00, 32'hABBAABBA, 1'b0, 1'b0, 1'b0, 32'd0, 1, 0);
    do_cmd("fifo_wr1", 2'd2, 1'b1, 8'h00, 32'h45632457, 1'b0, 1'b0, 1'b0, 32'd0, 1, 0);
    do_cmd("fifo_rd0", 2'd2, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'hABBAABBA, 2, 0);
    do_cmd("fifo_rd1", 2'd2, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h45632457, 2, 0);

    for (int i = 0; i < 4; i++)
      do_cmd("lifo_wr", 2'd1, 1'b1, 8'h00, 32'h10 + i, 1'b0, 1'b1, 1'b0, 32'd0, 1, 0);
    do_cmd("lifo_wr_full", 2'd1, 1'b1, 8'h00, 32'hDEAD0005, 1'b1, 1'b0, 1'b1, 32'd0, 1, 0);
    chk("lifo untouched", lifo_m.size(), 32'd4);
    do_cmd("lifo_rd", 2'd1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h13, 2, 0);

    do_cmd("hold_rd", 2'd0, 1'b0, 8'h03, 32'h0, 1'b0, 1'b0, 1'b0, 32'h12345678, 2, 5);

    // Reset while a read is in WAIT: the captured word must never surface.
    do_cmd("pre_wr", 2'd0, 1'b1, 8'h07, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'd0, 1, 0);
    cmd_target = 2'd0; cmd_write = 1'b0; cmd_addr = 8'h07; cmd_data = 32'h0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("wait_rst issue", {31'd0, valid}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("wait_rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("wait_rst rsp_data", rsp_data, 32'd0);
    chk("wait_rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("wait_rst din", din, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wait_rst idle", {31'd0, cmd_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("wait_rst no_rsp", {31'd0, rsp_valid}, 32'd0);

    do_cmd("after_rst", 2'd0, 1'b0, 8'h07, 32'h0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
